// File: rtl/msg_stream_sched.sv
// rtl/msg_stream_sched.sv - paced valid/ready streamer for four fixed ASCII messages
module msg_stream_sched #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       start,
    input  logic       repeat_en,
    input  logic       abort,
    input  logic       ready_in,
    output logic [7:0] char_out,
    output logic       valid_out,
    output logic       last_out,
    output logic [1:0] msg_id,
    output logic       busy,
    output logic       done
);

    // Counter only has to reach max(HOLD, GAP) - 1.
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    // Messages stored right-aligned, first character in the highest used byte.
    localparam logic [103:0] MSG0 = {32'd0, "Guatemala"};
    localparam logic [103:0] MSG1 = {48'd0, "Quetzal"};
    localparam logic [103:0] MSG2 = {56'd0, "Zacapa"};
    localparam logic [103:0] MSG3 = "Soy de Zacapa";

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    msg_id_nxt;
    logic          done_nxt;

    logic [103:0]  rom_vec;
    logic [3:0]    last_idx;
    logic [3:0]    pos;
    logic [7:0]    cur_char;
    logic          is_last;

    // Message ROM lookup for the latched selection and current index.
    always_comb begin
        rom_vec  = MSG0;
        last_idx = 4'd8;
        case (msg_id)
            2'd0: begin rom_vec = MSG0; last_idx = 4'd8;  end
            2'd1: begin rom_vec = MSG1; last_idx = 4'd6;  end
            2'd2: begin rom_vec = MSG2; last_idx = 4'd5;  end
            2'd3: begin rom_vec = MSG3; last_idx = 4'd12; end
            default: begin rom_vec = MSG0; last_idx = 4'd8; end
        endcase
        pos      = last_idx - idx;
        cur_char = rom_vec[{pos, 3'b000} +: 8];
        is_last  = (idx == last_idx);
    end

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= S_IDLE;
            idx    <= 4'd0;
            cnt    <= '0;
            msg_id <= 2'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            msg_id <= msg_id_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic; abort outranks every other transition once busy.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        msg_id_nxt = msg_id;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    msg_id_nxt = sel;
                    idx_nxt    = 4'd0;
                    cnt_nxt    = '0;
                    state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 4'd0;
                    cnt_nxt   = '0;
                end else if (ready_in) begin
                    cnt_nxt = '0;
                    if (is_last) begin
                        if (repeat_en) begin
                            state_nxt = S_GAP;
                        end else begin
                            state_nxt = S_IDLE;
                            idx_nxt   = 4'd0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx + 4'd1;
                        if (HOLD_CYCLES > 0) begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 4'd0;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = S_SEND;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 4'd0;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt  = S_SEND;
                    msg_id_nxt = sel;
                    idx_nxt    = 4'd0;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 4'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Character outputs are forced to zero whenever nothing is being offered.
    always_comb begin
        valid_out = (state == S_SEND);
        char_out  = (state == S_SEND) ? cur_char : 8'h00;
        last_out  = (state == S_SEND) && is_last;
        busy      = (state != S_IDLE);
    end

endmodule

// File: tb/tb_msg_stream_sched.sv
// tb/tb_msg_stream_sched.sv - directed self-checking bench for msg_stream_sched
module tb_msg_stream_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       start;
    logic       repeat_en;
    logic       abort;
    logic       ready_in;
    logic [7:0] char_out;
    logic       valid_out;
    logic       last_out;
    logic [1:0] msg_id;
    logic       busy;
    logic       done;

    int n_total;
    int n_pass;

    logic [7:0] exp_b[$];
    int         exp_c[$];
    logic       exp_l[$];
    logic [7:0] got_b[$];
    int         got_c[$];
    logic       got_l[$];
    logic [1:0] got_m[$];
    int         done_cyc;
    int         done_cnt;
    int         overlap;
    int         stall_bad;

    msg_stream_sched #(.HOLD_CYCLES(4), .GAP_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .start     (start),
        .repeat_en (repeat_en),
        .abort     (abort),
        .ready_in  (ready_in),
        .char_out  (char_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .msg_id    (msg_id),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected character k of a message starts at first + k*(1+HOLD) with HOLD=4.
    task automatic add_exp(input string s, input int first);
        for (int i = 0; i < s.len(); i++) begin
            exp_b.push_back(s[i]);
            exp_c.push_back(first + 5 * i);
            exp_l.push_back(i == s.len() - 1);
        end
    endtask

    task automatic clear_all();
        exp_b.delete(); exp_c.delete(); exp_l.delete();
        got_b.delete(); got_c.delete(); got_l.delete(); got_m.delete();
        done_cyc = -1; done_cnt = 0; overlap = 0; stall_bad = 0;
    endtask

    // Called at the sample point of cycle 1 (one edge after start was taken).
    task automatic collect(input int max_cyc, input int stall_at, input int stall_len,
                           input logic [7:0] stall_ch, input int sel_at,
                           input logic [1:0] sel_new, input int rep_off_at);
        int c;
        int stalled;
        bit fin;
        c = 1; stalled = 0; fin = 0;
        while (!fin && c <= max_cyc) begin
            if (stall_at >= 0 && got_b.size() == stall_at && stalled < stall_len &&
                (valid_out || stalled > 0)) begin
                ready_in = 1'b0;
                stalled++;
                if (!valid_out || char_out != stall_ch) stall_bad++;
            end else begin
                ready_in = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (valid_out) overlap++;
                fin = 1;
            end
            if (valid_out && ready_in) begin
                got_b.push_back(char_out);
                got_c.push_back(c);
                got_l.push_back(last_out);
                got_m.push_back(msg_id);
            end
            tick();
            c++;
            if (sel_at >= 0 && got_b.size() == sel_at) sel = sel_new;
            if (rep_off_at >= 0 && got_b.size() == rep_off_at) repeat_en = 1'b0;
        end
        if (!fin) chk("collect_timeout", 0, 1);
        if (done) done_cnt++;
    endtask

    task automatic compare_stream(input string tag);
        chk($sformatf("%s_len", tag), got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            chk($sformatf("%s_ch%0d", tag, i), got_b[i], exp_b[i]);
            chk($sformatf("%s_cy%0d", tag, i), got_c[i], exp_c[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
    endtask

    initial begin
        int n;
        int c;
        int d;
        n_total = 0; n_pass = 0;
        rst_n = 1'b1; sel = 2'd0; start = 1'b0; repeat_en = 1'b0;
        abort = 1'b0; ready_in = 1'b1;
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_char", char_out, 0);
        chk("rst_done", done, 0);
        chk("rst_msgid", msg_id, 0);
        tick(); tick();
        rst_n = 1'b0;
        tick();

        // Basic stream: Guatemala, ready always high.
        clear_all();
        sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
        chk("t1_first_valid", valid_out, 1);
        chk("t1_first_char", char_out, 8'h47);
        add_exp("Guatemala", 1);
        collect(100, -1, 0, 8'h00, -1, 2'd0, -1);
        compare_stream("t1");
        chk("t1_done_cyc", done_cyc, 42);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_overlap", overlap, 0);
        chk("t1_busy_after", busy, 0);

        // Backpressure on idx 2 of Quetzal for 5 cycles.
        clear_all();
        sel = 2'd1; start = 1'b1; tick(); start = 1'b0;
        exp_b = '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C};
        exp_c = '{1, 6, 16, 21, 26, 31, 36};
        exp_l = '{0, 0, 0, 0, 0, 0, 1};
        collect(100, 2, 5, 8'h65, -1, 2'd0, -1);
        compare_stream("t2");
        chk("t2_stall_bad", stall_bad, 0);
        chk("t2_done_cyc", done_cyc, 37);
        chk("t2_done_cnt", done_cnt, 1);

        // Repeat with reselection mid-message.
        clear_all();
        sel = 2'd2; repeat_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
        add_exp("Zacapa", 1);
        add_exp("Soy de Zacapa", 35);
        collect(200, -1, 0, 8'h00, 2, 2'd3, 6);
        compare_stream("t3");
        if (got_m.size() > 6) begin
            chk("t3_msgid_first", got_m[5], 2);
            chk("t3_msgid_second", got_m[6], 3);
        end else begin
            chk("t3_msgid_short", got_m.size(), 7);
        end
        chk("t3_done_cyc", done_cyc, 96);
        chk("t3_overlap", overlap, 0);

        // Abort during HOLD after the third character of Guatemala.
        sel = 2'd0; ready_in = 1'b1; start = 1'b1; tick(); start = 1'b0;
        n = 0; c = 0;
        while (n < 3 && c < 50) begin
            if (valid_out) n++;
            tick();
            c++;
        end
        chk("t4_in_hold", {busy, valid_out}, 2'b10);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_valid", valid_out, 0);
        chk("t4_done", done, 0);
        d = 0;
        repeat (4) begin
            tick();
            if (done) d++;
        end
        chk("t4_nodone", d, 0);
        sel = 2'd1; start = 1'b1; tick(); start = 1'b0;
        chk("t4_restart_char", char_out, 8'h51);
        chk("t4_restart_msgid", msg_id, 1);

        // Start while busy is ignored; abort and handshake on the same edge.
        sel = 2'd2; start = 1'b1; tick(); start = 1'b0;
        c = 0;
        while (!valid_out && c < 20) begin
            tick();
            c++;
        end
        chk("t5_next_char", char_out, 8'h75);
        chk("t5_msgid", msg_id, 1);
        abort = 1'b1; ready_in = 1'b1; tick(); abort = 1'b0;
        chk("t5_ab_busy", busy, 0);
        chk("t5_ab_valid", valid_out, 0);
        chk("t5_ab_done", done, 0);
        sel = 2'd1; ready_in = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("t5_idx_reset", char_out, 8'h51);

        // Asynchronous reset between edges while presenting a character.
        tick();
        chk("t6_pre_valid", valid_out, 1);
        #2 rst_n = 1'b1;
        #1;
        chk("t6_valid", valid_out, 0);
        chk("t6_char", char_out, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_msgid", msg_id, 0);
        #1 rst_n = 1'b0;
        ready_in = 1'b1;
        d = 0;
        repeat (5) begin
            tick();
            if (valid_out || busy) d++;
        end
        chk("t6_quiet", d, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msg_stream_sched.md
Name: msg_stream_sched

Overview:
- Sequencer that streams one of four fixed ASCII messages, character by character, to a downstream consumer (7-segment/character display driver or serial transmitter).
- Uses a valid/ready handshake.
- Owns the message index counter, inter-character pacing and optional auto-repeat.
- Latches the message selection only at message boundaries, so a switch change never corrupts a message in flight.

Parameters:
- HOLD_CYCLES, 4, idle cycles (valid low) inserted after each accepted non-last character; 0 = back-to-back.
- GAP_CYCLES, 8, idle cycles between the end of a message and its restart when repeating; must be ≥1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- sel  input  2  message select, sampled only at start or at repeat restart
- start  input  1  begin streaming; honoured only in IDLE
- repeat_en  input  1  restart the message after the gap; sampled at last-character handshake
- abort  input  1  terminate the current message
- ready_in  input  1  downstream accepts char_out this cycle
- char_out  output  8  current ASCII character
- valid_out  output  1  char_out valid
- last_out  output  1  char_out is the final character of the message
- msg_id  output  2  latched selection currently streaming
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse when a message completes without repeat

Behaviour:
- Message ROM (combinational, indexed by msg_id and idx):
  - 00 "Guatemala", length 9
  - 01 "Quetzal", length 7
  - 10 "Zacapa", length 6
  - 11 "Soy de Zacapa", length 13, space = 0x20
- idx is 4 bits; the hold/gap counter is wide enough for max(HOLD_CYCLES, GAP_CYCLES).
- Reset (asserted at any time, including mid-message): state IDLE, idx=0, counter=0, msg_id=0. All outputs 0 immediately, with no clock required.
- States: IDLE, SEND, HOLD, GAP.
- IDLE:
  - Outputs valid=0, busy=0.
  - start=1 at an edge: msg_id←sel, idx←0, →SEND.
  - valid_out rises exactly 1 cycle after start is sampled.
- SEND:
  - Outputs valid=1, char_out=ROM[msg_id][idx], last_out=(idx==len−1).
  - char_out, last_out and msg_id hold stable while ready_in=0. There is no timeout.
  - Handshake = valid_out & ready_in at an edge.
  - Handshake on a non-last character: idx←idx+1. Then →HOLD (counter←0) if HOLD_CYCLES>0, otherwise stay in SEND presenting the next character on the following cycle.
  - Handshake on the last character:
    - repeat_en=1: →GAP (counter←0).
    - repeat_en=0: →IDLE, idx←0, done=1 for the next cycle only.
- HOLD:
  - valid=0, counter increments each cycle.
  - When counter==HOLD_CYCLES−1: →SEND.
  - valid_out is therefore low for exactly HOLD_CYCLES cycles.
- GAP:
  - valid=0, counter increments each cycle.
  - When counter==GAP_CYCLES−1: msg_id←sel (re-sampled), idx←0, →SEND.
  - valid low for exactly GAP_CYCLES cycles.
- abort=1 in SEND/HOLD/GAP:
  - Next state is IDLE, idx←0, done not pulsed.
  - Abort has priority over every other transition.
  - If abort and a handshake occur in the same edge, that character counts as accepted downstream, but streaming stops.
  - abort in IDLE: no effect.
- start while busy: ignored.
- sel changes while busy: ignored until the next GAP→SEND restart or the next start.
- repeat_en changes before the last handshake: no effect.
- start and abort together in IDLE: start wins, since abort only acts when busy.
- done is asserted only in the cycle immediately after the final handshake; it never coincides with valid_out.
- Timing with ready_in tied high: a message of L characters occupies L + (L−1)·HOLD_CYCLES cycles from the first valid to the last handshake inclusive.

Test Plan:
- Basic stream: reset, sel=00, start pulse, ready=1, HOLD=4 → valid at cycle 1 after start. Bytes 47 75 61 74 65 6D 61 6C 61 each valid 1 cycle, separated by 4 low cycles; last_out only on the final 0x61; done pulses once 42 cycles after start; busy then drops.
- Backpressure: sel=01, ready_in=0 for 5 cycles on idx 2 → char_out stays 0x65 ('e'), valid stays high, no idx advance. The release yields 'e' then 't', z, a, l with no skipped or repeated byte.
- Repeat with reselection: sel=10, repeat_en=1, ready=1; change sel to 11 mid-message → "Zacapa" completes unchanged, valid low for 8 cycles, then "Soy de Zacapa" starts (0x53 first) with msg_id=11.
- Abort: abort during HOLD after the 3rd character of "Guatemala" → next cycle busy=0, valid=0, no done. A new start with sel=01 begins at 0x51.
- Abort+handshake same edge, and start-while-busy: the character is accepted once and state goes IDLE. A start pulse mid-message causes no restart and idx continues.
- Async reset mid-message (between clock edges, in SEND) → valid_out, char_out, busy, done read 0 before the next edge. After release, nothing streams until start.
